// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_device transmitter between NUM_REQ byte producers.
// Optional macro UART_TX_ARBITER_LOCK_EN adds a per-requester lock input for multi-byte packets.
module uart_tx_arbiter #(
  parameter int          NUM_REQ        = 4,
  parameter logic [15:0] BAUD_DIV       = 16'd12,
  parameter int          ACCEPT_TIMEOUT = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
`ifdef UART_TX_ARBITER_LOCK_EN
  input  logic [NUM_REQ-1:0]   lock,
`endif
  output logic [NUM_REQ-1:0]   ack,
  output logic                 busy,
  output logic                 cfg_error,
  output logic                 tx_error,
  output logic [3:0]           control_address,
  output logic                 control_write,
  output logic [15:0]          data_out,
  input  logic [7:0]           flags,
  input  logic [15:0]          control_read,
  output logic [2:0]           dbg_state
);

  // Handshakes: req[i] is a level with req_data[i] held stable until ack[i] pulses for one
  // cycle; the requester may change both from the following cycle. On the UART side flags[0]
  // is tx ready: control_write stays high on address 3 until flags[0] is seen low.
  typedef enum logic [2:0] {
    CFG_WRITE = 3'd0,
    CFG_CHECK = 3'd1,
    IDLE      = 3'd2,
    ISSUE     = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(ACCEPT_TIMEOUT + 1);

  state_t             r_state;
  logic [PW-1:0]      r_rr_ptr;
  logic [CW-1:0]      r_cnt;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_cfg_error;
  logic               r_tx_error;
  logic               r_write;
  logic [3:0]         r_addr;
  logic [15:0]        r_data;

  logic [PW-1:0]      w_rr_pick;
  logic [PW-1:0]      w_pick;
  logic [7:0]         w_byte;
  logic               w_any;
  logic               w_unused;

  assign w_any    = |req;
  assign w_unused = ^flags[7:1];

  // Offsets are scanned from farthest to nearest so the requester closest after r_rr_ptr wins.
  always_comb begin
    w_rr_pick = r_rr_ptr;
    for (int i = NUM_REQ; i >= 1; i--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (req[j] && ((int'(r_rr_ptr) + i) % NUM_REQ == j)) w_rr_pick = PW'(j);
      end
    end
  end

`ifdef UART_TX_ARBITER_LOCK_EN
  logic r_prev_valid;
  logic w_lock_hit;
  // The previous winner keeps the grant; r_rr_ptr already points at it, so it stays put.
  assign w_lock_hit = r_prev_valid && req[r_rr_ptr] && lock[r_rr_ptr];
  assign w_pick     = w_lock_hit ? r_rr_ptr : w_rr_pick;
`else
  assign w_pick     = w_rr_pick;
`endif

  always_comb begin
    w_byte = 8'h00;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (PW'(j) == w_pick) w_byte = req_data[8*j +: 8];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= CFG_WRITE;
      r_rr_ptr    <= PW'(NUM_REQ - 1);
      r_cnt       <= '0;
      r_ack       <= '0;
      r_cfg_error <= 1'b0;
      r_tx_error  <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= 4'h2;
      r_data      <= '0;
`ifdef UART_TX_ARBITER_LOCK_EN
      r_prev_valid <= 1'b0;
`endif
    end else begin
      r_ack <= '0;
      case (r_state)
        CFG_WRITE: begin
          r_addr <= 4'h2;
          if (!r_write) begin
            r_write <= 1'b1;
            r_data  <= BAUD_DIV;
          end else begin
            r_write <= 1'b0;
            r_state <= CFG_CHECK;
          end
        end
        CFG_CHECK: begin
          if (control_read != BAUD_DIV) r_cfg_error <= 1'b1;
          r_addr  <= 4'h3;
          r_state <= IDLE;
        end
        IDLE: begin
          r_write <= 1'b0;
          r_addr  <= 4'h3;
          if (flags[0] && w_any) begin
            r_data   <= {8'h00, w_byte};
            r_ack    <= NUM_REQ'(1) << w_pick;
            r_rr_ptr <= w_pick;
            r_write  <= 1'b1;
            r_cnt    <= '0;
            r_state  <= ISSUE;
`ifdef UART_TX_ARBITER_LOCK_EN
            r_prev_valid <= 1'b1;
`endif
          end
        end
        ISSUE: begin
          // Dropping write on the edge that sees ready low keeps the UART to a single byte.
          if (!flags[0]) begin
            r_write <= 1'b0;
            r_state <= WAIT_DONE;
          end else if (r_cnt == CW'(ACCEPT_TIMEOUT - 1)) begin
            r_tx_error <= 1'b1;
            r_write    <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          r_write <= 1'b0;
          if (flags[0]) r_state <= IDLE;
        end
        default: r_state <= CFG_WRITE;
      endcase
    end
  end

  assign ack             = r_ack;
  assign busy            = (r_state != IDLE);
  assign cfg_error       = r_cfg_error;
  assign tx_error        = r_tx_error;
  assign control_address = r_addr;
  assign control_write   = r_write;
  assign data_out        = r_data;
  assign dbg_state       = r_state;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single uart_device transmitter between NUM_REQ byte producers.
- Drives the UART control port (control_address / control_write / data_in).
- After reset, writes and verifies the baud divider.
- Then grants requesters round-robin and issues each byte to TX data register 3, pacing on flags[0] (tx ready).

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- BAUD_DIV, 16'd12: value written to control register 2 after reset.
- ACCEPT_TIMEOUT, 64: cycles to wait for flags[0] to fall after a TX write before flagging an error.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester byte-pending level.
- req_data  in  8*NUM_REQ  byte for requester i in bits [8i+7:8i].
- ack  out  NUM_REQ  one-cycle pulse; byte for requester i latched.
- busy  out  1  high whenever state != IDLE.
- cfg_error  out  1  sticky; divider readback mismatch.
- tx_error  out  1  sticky; ACCEPT_TIMEOUT expired.
- control_address  out  4  to uart_device.
- control_write  out  1  to uart_device.
- data_out  out  16  to uart_device data_in.
- flags  in  8  from uart_device; bit 0 = tx ready.
- control_read  in  16  from uart_device.

Behaviour:
- Reset values: control_address=4'h2, control_write=0, data_out=0, ack=0, cfg_error=0, tx_error=0, rr_ptr=NUM_REQ-1, state=CFG_WRITE, busy=1.
- CFG_WRITE, 1 cycle:
  - control_address=2, data_out=BAUD_DIV, control_write=1.
  - Goes to CFG_CHECK.
- CFG_CHECK, 1 cycle:
  - control_write=0, control_address=2.
  - If control_read != BAUD_DIV, set cfg_error.
  - Always goes to IDLE; no retry.
- IDLE:
  - control_write=0, control_address=3.
  - When flags[0]=1 and any req bit is set, select the first requester set, searching from rr_ptr+1 modulo NUM_REQ.
  - Latch req_data of the winner into data_out[7:0], with data_out[15:8]=0.
  - Pulse ack[winner] in that same cycle, update rr_ptr=winner, then go to ISSUE.
  - A requester may change req/req_data from the cycle after its ack.
- ISSUE:
  - control_write=1 and control_address=3, held until flags[0] is sampled 0; then go to WAIT_DONE.
  - control_write must drop in the cycle after flags[0] is seen low, so the UART never picks up a second byte.
  - Cycle counter starts at 0 on entry.
  - If it reaches ACCEPT_TIMEOUT, set tx_error, drop control_write, return to IDLE. The byte is lost and has already been acked.
- WAIT_DONE:
  - control_write=0; wait for flags[0]=1 (stop bit finished), then go to IDLE.
  - Minimum byte-to-byte spacing is therefore one full UART frame plus 2 cycles.
- Simultaneous requests: exactly one ack per granted byte; only one bit of ack is ever high.
- A req dropped before grant is simply skipped.
- flags[0]=1 while in IDLE with no requests: stay in IDLE, no writes.
- Reset asserted mid-operation:
  - All outputs return immediately to reset values; control_write=0 asynchronously.
  - Config write sequence reruns after release; the in-flight byte is abandoned.
- rr_ptr wraps from NUM_REQ-1 to 0.

Optional Feature:
- Macro: UART_TX_ARBITER_LOCK_EN.
- When defined:
  - Adds input lock, NUM_REQ wide.
  - In IDLE, if the previous winner still has req and lock set, it is granted again, bypassing round-robin.
  - This allows back-to-back multi-byte packets; rr_ptr is not updated while the lock is honoured.
- When undefined:
  - The lock port does not exist.
  - Pure round-robin, one byte per grant.

Test Plan:
- Reset release with control_read returning 16'd12 -> one cycle of address 2 / data 16'h000C / write=1, then IDLE with busy=0 and cfg_error=0.
- Reset with control_read returning 16'd5 -> cfg_error=1 and stays 1 through later traffic until the next reset.
- Single requester: req[0]=1, req_data=8'hAA, model UART drops flags[0] 2 cycles after write and raises it 40 cycles later:
  - Expected: ack[0] pulse, data_out=16'h00AA, write held exactly until flags[0]=0.
  - Expected: next byte issued only after flags[0]=1.
- All 4 requesting continuously -> grant order 0,1,2,3,0 with exactly one ack per UART frame.
- flags[0] stuck at 1 after a write -> tx_error=1 after 64 cycles, control_write=0, arbiter returns to IDLE and serves the next request.
- Reset asserted during WAIT_DONE:
  - Expected: control_write=0 immediately and ack=0.
  - Expected: after release, the config write repeats and rr_ptr restarts so requester 0 is served first.
